// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces in a small FIFO and sends each one as four 8N1 UART bytes,
// most-significant byte first.
module golden_nonce_uart_tx #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       hash_clk,
  input  logic                       reset,
  input  logic                       nonce_valid,
  input  logic [31:0]                golden_nonce,
  output logic                       uart_tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int unsigned Depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] CountFull = (FIFO_DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                     state_q = StIdle;
  state_e                     state_d;
  logic [TimerW-1:0]          timer_q = '0;
  logic [TimerW-1:0]          timer_d;
  logic [2:0]                 bit_idx_q = '0;
  logic [2:0]                 bit_idx_d;
  logic [1:0]                 byte_idx_q = '0;
  logic [1:0]                 byte_idx_d;
  logic [31:0]                shift_q = '0;
  logic [31:0]                shift_d;
  logic                       tx_q = 1'b1;
  logic                       tx_d;

  logic [31:0]                mem_q [Depth] = '{default: '0};
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q = '0;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q = '0;
  logic [FIFO_DEPTH_LOG2:0]   count_q = '0;
  logic                       ovf_q = 1'b0;

  logic pop, push, drop, bit_end;

  // A full FIFO still accepts a strobe when the TX side pops on the same edge.
  always_comb begin
    pop     = (state_q == StIdle) && (count_q != '0);
    push    = nonce_valid && ((count_q != CountFull) || pop);
    drop    = nonce_valid && !push;
    bit_end = (timer_q == TimerMax);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          timer_d    = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        // The byte on the line always sits in shift_q[31:24].
        tx_d = shift_q[{2'b11, bit_idx_q}];
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          timer_d = '0;
          if (byte_idx_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = shift_q << 8;
            state_d    = StStart;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= golden_nonce;
  end

  assign uart_tx    = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Randomized and directed bench for golden_nonce_uart_tx against a cycle-level
// transaction model (nonce queue plus frame-position arithmetic).
module tb_golden_nonce_uart_tx;

  localparam int unsigned Cpb         = 4;
  localparam int unsigned Log2        = 2;
  localparam int unsigned Depth       = 1 << Log2;
  localparam int          FrameCycles = 40 * Cpb;
  localparam int          NoFrame     = 100000;

  logic           hash_clk = 1'b0;
  logic           reset = 1'b1;
  logic           nonce_valid = 1'b0;
  logic [31:0]    golden_nonce = '0;
  logic           uart_tx;
  logic           busy;
  logic           overflow;
  logic [Log2:0]  fifo_count;

  golden_nonce_uart_tx #(
    .CLKS_PER_BIT    (Cpb),
    .FIFO_DEPTH_LOG2 (Log2)
  ) dut (
    .hash_clk     (hash_clk),
    .reset        (reset),
    .nonce_valid  (nonce_valid),
    .golden_nonce (golden_nonce),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 hash_clk = ~hash_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Reference model: pending queue, nonce on the line, cycles left in frame,
  // edges since the pop that started the current frame.
  logic [31:0] mq[$];
  logic [31:0] m_cur   = '0;
  int          m_left  = 0;
  int          m_since = NoFrame;
  bit          m_ovf   = 1'b0;
  int          edge_n  = 0;

  // Frame = 4 x (start, 8 data LSB first, stop); line lags the pop by one edge.
  function automatic logic exp_tx();
    int k, bitno, b, pos;
    k = m_since - 1;
    if (k < 0 || k >= FrameCycles) return 1'b1;
    bitno = k / Cpb;
    b     = bitno / 10;
    pos   = bitno % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_cur[8 * (3 - b) + pos - 1];
  endfunction

  task automatic cycle(input bit v, input logic [31:0] d, input bit r);
    bit idle, pop;
    nonce_valid  = v;
    golden_nonce = d;
    reset        = r;
    @(posedge hash_clk);
    edge_n++;
    if (r) begin
      mq.delete();
      m_left  = 0;
      m_since = NoFrame;
      m_ovf   = 1'b0;
    end else begin
      idle = (m_left == 0);
      pop  = idle && (mq.size() > 0);
      if (!idle) m_left--;
      if (m_since < NoFrame) m_since++;
      if (pop) begin
        m_cur   = mq.pop_front();
        m_left  = FrameCycles;
        m_since = 0;
      end
      if (v) begin
        if (mq.size() < Depth) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_eq("uart_tx", uart_tx, exp_tx());
    check_eq("busy", busy, (m_left != 0) || (mq.size() != 0));
    check_eq("fifo_count", fifo_count, mq.size());
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, 32'h0, 1'b0);
  endtask

  int s_edge;

  initial begin
    // Reset state
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    check_eq("rst_tx", uart_tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_count", fifo_count, 0);

    // Single nonce strobed on edge 10
    while (edge_n < 9) idle_cycles(1);
    cycle(1'b1, 32'h01D0_0C5A, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    check_eq("lat_hi_11", uart_tx, 1);
    cycle(1'b0, 32'h0, 1'b0);
    check_eq("lat_lo_12", uart_tx, 0);
    while (edge_n < 170) idle_cycles(1);
    check_eq("busy_170", busy, 1);
    idle_cycles(1);
    check_eq("busy_171", busy, 0);
    idle_cycles(10);

    // Back-to-back: three strobes
    repeat (3) cycle(1'b1, $urandom, 1'b0);
    idle_cycles(3 * (FrameCycles + 1) + 10);
    check_eq("b2b_ovf", overflow, 0);
    check_eq("b2b_busy", busy, 0);

    // Overflow: six strobes, one dropped
    cycle(1'b0, 32'h0, 1'b1);
    repeat (6) cycle(1'b1, $urandom, 1'b0);
    check_eq("ovf_count", fifo_count, 4);
    check_eq("ovf_set", overflow, 1);
    idle_cycles(5 * (FrameCycles + 1) + 10);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_drained", busy, 0);

    // Full FIFO with a strobe on the pop edge
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, $urandom, 1'b0);
    s_edge = edge_n;
    repeat (4) cycle(1'b1, $urandom, 1'b0);
    check_eq("full_count", fifo_count, 4);
    while (edge_n < s_edge + FrameCycles + 1) idle_cycles(1);
    cycle(1'b1, 32'hA5A5_0F0F, 1'b0);
    check_eq("full_simul_count", fifo_count, 4);
    check_eq("full_simul_ovf", overflow, 0);
    idle_cycles(5 * (FrameCycles + 1) + 10);

    // Reset during data bits of byte 2 with two nonces queued
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, $urandom, 1'b0);
    s_edge = edge_n;
    repeat (2) cycle(1'b1, $urandom, 1'b0);
    while (edge_n < s_edge + 1 + Cpb * 23 + 1) idle_cycles(1);
    cycle(1'b0, 32'h0, 1'b1);
    check_eq("midrst_tx", uart_tx, 1);
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_busy", busy, 0);
    idle_cycles(400);

    // Random traffic with occasional bursts and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        repeat (6) cycle(1'b1, $urandom, 1'b0);
      end else begin
        cycle($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 1499) == 0);
      end
    end
    idle_cycles(5 * (FrameCycles + 1) + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
